// File: rtl/rv_ctl_pkg.sv
// rv_ctl_pkg
// Shared definitions for the multicycle RISC-V control plane:
//   - opcode / {opcode,funct3} decode keys for the supported instructions
//   - datapath mux-select encodings (PC, writeback, immediate, ALU A/B, ALU op)
//   - controller state type and a helper that flags the memory states
package rv_ctl_pkg;

   // Major opcodes (instr[6:0])
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_ALU    = 7'b0110011;
   localparam logic [6:0] OP_ALUI   = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   // Decode keys {instr[6:0], instr[14:12]}; R-type ALU and JAL ignore funct3
   localparam logic [9:0] OPF_LW   = {OP_LOAD,   3'b010};
   localparam logic [9:0] OPF_SW   = {OP_STORE,  3'b010};
   localparam logic [9:0] OPF_BEQ  = {OP_BRANCH, 3'b000};
   localparam logic [9:0] OPF_ADDI = {OP_ALUI,   3'b000};
   localparam logic [9:0] OPF_XORI = {OP_ALUI,   3'b100};

   // PC source
   localparam logic       PC_INC = 1'b0;
   localparam logic       PC_ALU = 1'b1;
   // Writeback select
   localparam logic [1:0] WB_PC     = 2'd0;
   localparam logic [1:0] WB_ALUOUT = 2'd1;
   localparam logic [1:0] WB_MDR    = 2'd2;
   // Immediate type (IMM_L covers loads and I-type ALU ops)
   localparam logic [1:0] IMM_B = 2'd0;
   localparam logic [1:0] IMM_L = 2'd1;
   localparam logic [1:0] IMM_S = 2'd2;
   localparam logic [1:0] IMM_J = 2'd3;
   // ALU operand selects
   localparam logic [1:0] ALUA_REG = 2'd0;
   localparam logic [1:0] ALUA_PCC = 2'd1;
   localparam logic [1:0] ALUB_REG = 2'd0;
   localparam logic [1:0] ALUB_IMM = 2'd1;
   // ALU operation, encoded as {funct3, instr[30]}
   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_ADDR, S_LW_MEM, S_LW_WB, S_SW_MEM,
      S_RTYPE_ALU, S_ITYPE_ALU, S_ALU_WB, S_BEQ_EXEC, S_JAL_EXEC, S_ERROR
   } state_e;

   // States that hold a memory request open
   function automatic logic is_mem_state(state_e s);
      return (s == S_FETCH) || (s == S_LW_MEM) || (s == S_SW_MEM);
   endfunction

endpackage

// File: rtl/rv_ctl_hs_if.sv
// rv_ctl_hs_if
// Request/ready handshake between the controller and the unified memory.
//   mem_req   : request valid (controller -> memory)
//   memrw     : 1 = write, 0 = read; valid with mem_req
//   mem_ready : memory completes the current request (memory -> controller)
interface rv_ctl_hs_if;
   logic mem_req;
   logic memrw;
   logic mem_ready;

   modport master (output mem_req, output memrw, input mem_ready);
   modport slave  (input mem_req, input memrw, output mem_ready);
endinterface

// File: rtl/rv_mem_wait.sv
// rv_mem_wait
// Wait-state counter with timeout compare for one memory request.
//   clk, rst : clock, asynchronous active-high reset
//   start    : clear the counter (asserted on the cycle a memory state is entered)
//   ready    : 1 when no wait is being spent this cycle
//   expired  : this cycle is the TIMEOUT-th wait cycle with no ready
module rv_mem_wait #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic ready,
   output logic expired
);
   // Counter holds the number of wait cycles already spent, so the
   // TIMEOUT-th wait cycle is the one that sees TIMEOUT-1 here.
   localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

   logic [7:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (start) begin
         cnt_d = '0;
      end else if (!ready && (cnt_q != LAST)) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // A ready on the limit cycle wins over the timeout
   assign expired = !ready && (cnt_q == LAST);
endmodule

// File: rtl/rv_ctl_hs.sv
// rv_ctl_hs
// Multicycle RISC-V controller with memory handshake, I-type ALU path,
// retired-instruction counter and error/illegal status.
//   clk, rst        : clock, asynchronous active-high reset
//   instr, zero     : IR contents and ALU zero flag from the datapath
//   mem             : request/ready handshake to memory (master side)
//   pcsourse..alusel: datapath control strobes and mux selects
//   instret         : retired-instruction count (wraps)
//   mem_err         : sticky memory-timeout flag
//   illegal         : one-cycle pulse on an unimplemented instruction
module rv_ctl_hs
   import rv_ctl_pkg::*;
#(
   parameter int TIMEOUT  = 15,
   parameter int EN_ITYPE = 1,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      instr,
   input  logic             zero,
   rv_ctl_hs_if.master      mem,
   output logic             pcsourse,
   output logic             pcwrite,
   output logic             pccen,
   output logic             irwrite,
   output logic             mdrwrite,
   output logic [1:0]       wbsel,
   output logic             regwen,
   output logic [1:0]       immsel,
   output logic [1:0]       asel,
   output logic [1:0]       bsel,
   output logic [3:0]       alusel,
   output logic [CNT_W-1:0] instret,
   output logic             mem_err,
   output logic             illegal
);
   localparam bit ITYPE_ON = (EN_ITYPE != 0);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] instret_q;
   logic             mem_err_q;
   logic             mem_req_c, memrw_c;
   logic             retire, set_err;
   logic             wait_start, wait_ready, wait_expired;

   logic [9:0] key;
   logic [6:0] opc;
   assign key = {instr[6:0], instr[14:12]};
   assign opc = instr[6:0];

   // Fields of the IR the controller never looks at
   logic unused_instr_bits;
   assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

   // Outside a memory state there is no wait to count
   assign wait_ready = is_mem_state(state_q) ? mem.mem_ready : 1'b1;
   assign wait_start = is_mem_state(state_d) && (state_d != state_q);

   rv_mem_wait #(.TIMEOUT(TIMEOUT)) u_wait (
      .clk     (clk),
      .rst     (rst),
      .start   (wait_start),
      .ready   (wait_ready),
      .expired (wait_expired)
   );

   always_comb begin
      state_d   = state_q;
      mem_req_c = 1'b0;
      memrw_c   = 1'b0;
      pcsourse  = PC_INC;
      pcwrite   = 1'b0;
      pccen     = 1'b0;
      irwrite   = 1'b0;
      mdrwrite  = 1'b0;
      wbsel     = WB_PC;
      regwen    = 1'b0;
      immsel    = IMM_B;
      asel      = ALUA_REG;
      bsel      = ALUB_REG;
      alusel    = ALU_ADD;
      illegal   = 1'b0;
      retire    = 1'b0;
      set_err   = 1'b0;
      // Reset is asynchronous: gate the outputs directly so an open
      // request drops in the same cycle rst rises.
      if (!rst) begin
         unique case (state_q)
            S_FETCH: begin
               mem_req_c = 1'b1;
               if (mem.mem_ready) begin
                  pcwrite = 1'b1;
                  pccen   = 1'b1;
                  irwrite = 1'b1;
                  state_d = S_DECODE;
               end else if (wait_expired) begin
                  set_err = 1'b1;
                  state_d = S_ERROR;
               end
            end
            S_DECODE: begin
               // Branch target precomputed from the PC copy
               asel   = ALUA_PCC;
               bsel   = ALUB_IMM;
               immsel = IMM_B;
               if (key == OPF_LW || key == OPF_SW)                  state_d = S_ADDR;
               else if (opc == OP_ALU)                             state_d = S_RTYPE_ALU;
               else if (key == OPF_BEQ)                            state_d = S_BEQ_EXEC;
               else if (opc == OP_JAL)                             state_d = S_JAL_EXEC;
               else if (ITYPE_ON && (key == OPF_ADDI || key == OPF_XORI)) state_d = S_ITYPE_ALU;
               else begin
                  illegal = 1'b1;
                  state_d = S_FETCH;
               end
            end
            S_ADDR: begin
               bsel    = ALUB_IMM;
               immsel  = (key == OPF_SW) ? IMM_S : IMM_L;
               state_d = (key == OPF_SW) ? S_SW_MEM : S_LW_MEM;
            end
            S_LW_MEM: begin
               mem_req_c = 1'b1;
               if (mem.mem_ready) begin
                  mdrwrite = 1'b1;
                  state_d  = S_LW_WB;
               end else if (wait_expired) begin
                  set_err = 1'b1;
                  state_d = S_ERROR;
               end
            end
            S_LW_WB: begin
               wbsel   = WB_MDR;
               regwen  = 1'b1;
               retire  = 1'b1;
               state_d = S_FETCH;
            end
            S_SW_MEM: begin
               mem_req_c = 1'b1;
               memrw_c   = 1'b1;
               if (mem.mem_ready) begin
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end else if (wait_expired) begin
                  set_err = 1'b1;
                  state_d = S_ERROR;
               end
            end
            S_RTYPE_ALU: begin
               alusel  = {instr[14:12], instr[30]};
               state_d = S_ALU_WB;
            end
            S_ITYPE_ALU: begin
               immsel  = IMM_L;
               bsel    = ALUB_IMM;
               alusel  = {instr[14:12], 1'b0};
               state_d = S_ALU_WB;
            end
            S_ALU_WB: begin
               wbsel   = WB_ALUOUT;
               regwen  = 1'b1;
               retire  = 1'b1;
               state_d = S_FETCH;
            end
            S_BEQ_EXEC: begin
               alusel   = ALU_SUB;
               pcsourse = PC_ALU;
               pcwrite  = zero;
               retire   = 1'b1;
               state_d  = S_FETCH;
            end
            S_JAL_EXEC: begin
               asel     = ALUA_PCC;
               bsel     = ALUB_IMM;
               immsel   = IMM_J;
               pcsourse = PC_ALU;
               pcwrite  = 1'b1;
               regwen   = 1'b1;
               wbsel    = WB_PC;
               retire   = 1'b1;
               state_d  = S_FETCH;
            end
            default: state_d = S_ERROR;  // S_ERROR is terminal until reset
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_FETCH;
         instret_q <= '0;
         mem_err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (retire)  instret_q <= instret_q + CNT_W'(1);
         if (set_err) mem_err_q <= 1'b1;
      end
   end

   assign mem.mem_req = mem_req_c;
   assign mem.memrw   = memrw_c;
   assign instret     = instret_q;
   assign mem_err     = mem_err_q;
endmodule

// File: tb/tb_rv_ctl_hs.sv
// tb_rv_ctl_hs
// Two controllers: dut1 (I-type enabled, 32-bit counter) and dut0 (I-type
// disabled, 4-bit counter so wrap-around is reached). Only one is active at
// a time; the other is held in reset. For every instruction the bench builds
// the expected per-cycle output trace from the instruction class and the
// chosen wait-state counts, plays it, and a single compare process checks
// the active controller against it on every cycle.
module tb_rv_ctl_hs;
   import rv_ctl_pkg::*;

   localparam int TO = 15;

   typedef struct packed {
      logic       mem_req, memrw, pcsourse, pcwrite, pccen, irwrite, mdrwrite;
      logic [1:0] wbsel;
      logic       regwen;
      logic [1:0] immsel, asel, bsel;
      logic [3:0] alusel;
      logic       mem_err, illegal;
   } ctl_t;

   typedef enum int {K_LW, K_SW, K_R, K_ADDI, K_XORI, K_BEQ, K_JAL, K_ILL} kind_e;

   typedef struct {
      ctl_t c;
      bit   rdy;
      bit   z;
      bit   ret;
   } ent_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst1, rst0, zero, mem_ready;
   logic [31:0] instr;

   rv_ctl_hs_if mem1();
   rv_ctl_hs_if mem0();
   assign mem1.mem_ready = mem_ready;
   assign mem0.mem_ready = mem_ready;

   logic        pcs1, pcw1, pcc1, irw1, mdr1, rgw1, ill1, err1;
   logic [1:0]  wb1, imm1, as1, bs1;
   logic [3:0]  alu1;
   logic [31:0] cnt1;
   logic        pcs0, pcw0, pcc0, irw0, mdr0, rgw0, ill0, err0;
   logic [1:0]  wb0, imm0, as0, bs0;
   logic [3:0]  alu0;
   logic [3:0]  cnt0;

   rv_ctl_hs #(.TIMEOUT(TO), .EN_ITYPE(1), .CNT_W(32)) dut1 (
      .clk(clk), .rst(rst1), .instr(instr), .zero(zero), .mem(mem1),
      .pcsourse(pcs1), .pcwrite(pcw1), .pccen(pcc1), .irwrite(irw1), .mdrwrite(mdr1),
      .wbsel(wb1), .regwen(rgw1), .immsel(imm1), .asel(as1), .bsel(bs1), .alusel(alu1),
      .instret(cnt1), .mem_err(err1), .illegal(ill1)
   );

   rv_ctl_hs #(.TIMEOUT(TO), .EN_ITYPE(0), .CNT_W(4)) dut0 (
      .clk(clk), .rst(rst0), .instr(instr), .zero(zero), .mem(mem0),
      .pcsourse(pcs0), .pcwrite(pcw0), .pccen(pcc0), .irwrite(irw0), .mdrwrite(mdr0),
      .wbsel(wb0), .regwen(rgw0), .immsel(imm0), .asel(as0), .bsel(bs0), .alusel(alu0),
      .instret(cnt0), .mem_err(err0), .illegal(ill0)
   );

   ctl_t act1, act0;
   assign act1 = {mem1.mem_req, mem1.memrw, pcs1, pcw1, pcc1, irw1, mdr1, wb1, rgw1,
                  imm1, as1, bs1, alu1, err1, ill1};
   assign act0 = {mem0.mem_req, mem0.memrw, pcs0, pcw0, pcc0, irw0, mdr0, wb0, rgw0,
                  imm0, as0, bs0, alu0, err0, ill0};

   ent_t        trace[$];
   int          checks = 0, fails = 0;
   int          model_cnt = 0, cyc_no = 0, tx_no = 0;
   int          mdr_seen = 0, req_seen = 0;
   bit          sel = 1'b1, chk_en = 1'b0;
   ctl_t        exp_ctl;
   logic [31:0] exp_cnt;
   ctl_t        cmp_a;
   logic [31:0] cmp_c, cmp_e;

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         cmp_a = sel ? act1 : act0;
         cmp_c = sel ? cnt1 : {28'd0, cnt0};
         cmp_e = sel ? exp_cnt : (exp_cnt & 32'hF);
         checks++;
         if (cmp_a !== exp_ctl) begin
            fails++;
            $display("FAIL ctl dut%0d cycle=%0d got=%06h want=%06h", sel, cyc_no, cmp_a, exp_ctl);
         end
         checks++;
         if (cmp_c !== cmp_e) begin
            fails++;
            $display("FAIL instret dut%0d cycle=%0d got=%0d want=%0d", sel, cyc_no, cmp_c, cmp_e);
         end
         if (sel && cmp_a.mdrwrite) mdr_seen++;
         if (sel && cmp_a.mem_req)  req_seen++;
      end
   end

   // ---------------- model helpers ----------------
   function automatic bit rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic ctl_t idle();
      ctl_t c;
      c          = '0;
      c.pcsourse = PC_INC;
      c.wbsel    = WB_PC;
      c.immsel   = IMM_B;
      c.asel     = ALUA_REG;
      c.bsel     = ALUB_REG;
      c.alusel   = ALU_ADD;
      return c;
   endfunction

   function automatic kind_e classify(input logic [31:0] ins, input bit en);
      logic [6:0] op;
      logic [2:0] f3;
      op = ins[6:0];
      f3 = ins[14:12];
      if (op == 7'h03 && f3 == 3'd2) return K_LW;
      if (op == 7'h23 && f3 == 3'd2) return K_SW;
      if (op == 7'h33)               return K_R;
      if (op == 7'h63 && f3 == 3'd0) return K_BEQ;
      if (op == 7'h6F)               return K_JAL;
      if (op == 7'h13 && f3 == 3'd0) return en ? K_ADDI : K_ILL;
      if (op == 7'h13 && f3 == 3'd4) return en ? K_XORI : K_ILL;
      return K_ILL;
   endfunction

   task automatic add(input ctl_t c, input bit rdy, input bit z, input bit ret);
      ent_t e;
      e.c = c; e.rdy = rdy; e.z = z; e.ret = ret;
      trace.push_back(e);
   endtask

   // A memory phase: w wait cycles then the accepting cycle, or a timeout
   // after TO waits followed by a few cycles parked in the error state.
   task automatic mem_phase(input ctl_t busy, input ctl_t done, input int w,
                            input bit ret, output bit err);
      ctl_t e;
      err = (w >= TO);
      for (int i = 0; i < (err ? TO : w); i++) add(busy, 1'b0, rb(), 1'b0);
      if (err) begin
         e = idle();
         e.mem_err = 1'b1;
         for (int i = 0; i < 3; i++) add(e, rb(), rb(), 1'b0);
      end else begin
         add(done, 1'b1, rb(), ret);
      end
   endtask

   task automatic build(input logic [31:0] ins, input bit en, input int fw, input int mw,
                        input bit z, output bit err);
      ctl_t  c, d;
      kind_e k;
      trace.delete();
      c = idle(); c.mem_req = 1'b1;
      d = c; d.pcwrite = 1'b1; d.pccen = 1'b1; d.irwrite = 1'b1; d.pcsourse = PC_INC;
      mem_phase(c, d, fw, 1'b0, err);
      if (err) return;
      k = classify(ins, en);
      c = idle(); c.asel = ALUA_PCC; c.bsel = ALUB_IMM; c.immsel = IMM_B;
      if (k == K_ILL) begin
         c.illegal = 1'b1;
         add(c, rb(), rb(), 1'b0);
         return;
      end
      add(c, rb(), rb(), 1'b0);
      case (k)
         K_LW, K_SW: begin
            c = idle(); c.bsel = ALUB_IMM; c.immsel = (k == K_LW) ? IMM_L : IMM_S;
            add(c, rb(), rb(), 1'b0);
            c = idle(); c.mem_req = 1'b1; c.memrw = (k == K_SW);
            d = c; d.mdrwrite = (k == K_LW);
            mem_phase(c, d, mw, (k == K_SW), err);
            if (err) return;
            if (k == K_LW) begin
               c = idle(); c.wbsel = WB_MDR; c.regwen = 1'b1;
               add(c, rb(), rb(), 1'b1);
            end
         end
         K_R, K_ADDI, K_XORI: begin
            c = idle();
            if (k == K_R) begin
               c.alusel = {ins[14:12], ins[30]};
            end else begin
               c.immsel = IMM_L; c.bsel = ALUB_IMM; c.alusel = {ins[14:12], 1'b0};
            end
            add(c, rb(), rb(), 1'b0);
            c = idle(); c.wbsel = WB_ALUOUT; c.regwen = 1'b1;
            add(c, rb(), rb(), 1'b1);
         end
         K_BEQ: begin
            c = idle(); c.alusel = ALU_SUB; c.pcsourse = PC_ALU; c.pcwrite = z;
            add(c, rb(), z, 1'b1);
         end
         default: begin // K_JAL
            c = idle(); c.asel = ALUA_PCC; c.bsel = ALUB_IMM; c.immsel = IMM_J;
            c.pcsourse = PC_ALU; c.pcwrite = 1'b1; c.regwen = 1'b1; c.wbsel = WB_PC;
            add(c, rb(), rb(), 1'b1);
         end
      endcase
   endtask

   // ---------------- stimulus ----------------
   task automatic cyc(input ctl_t c, input bit rdy, input bit z);
      exp_ctl   = c;
      exp_cnt   = 32'(model_cnt);
      mem_ready = rdy;
      zero      = z;
      chk_en    = 1'b1;
      cyc_no++;
      @(posedge clk);
      #1;
   endtask

   task automatic play(input int limit);
      for (int i = 0; i < trace.size() && (limit < 0 || i < limit); i++) begin
         cyc(trace[i].c, trace[i].rdy, trace[i].z);
         if (trace[i].ret) model_cnt++;
      end
   endtask

   task automatic do_reset(input bit which);
      if (which) rst1 = 1'b1; else rst0 = 1'b1;
      model_cnt = 0;
      cyc(idle(), rb(), rb());
      cyc(idle(), rb(), rb());
      if (which) rst1 = 1'b0; else rst0 = 1'b0;
   endtask

   task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   task automatic run_tx(input logic [31:0] ins, input bit en, input int fw, input int mw,
                         input bit z, input int limit, output int ncyc, output bit err);
      instr = ins;
      build(ins, en, fw, mw, z, err);
      ncyc = trace.size();
      tx_no++;
      $display("tx %0d dut%0d instr=%08h kind=%0d fw=%0d mw=%0d z=%0d cycles=%0d timeout=%0d",
               tx_no, sel, ins, classify(ins, en), fw, mw, z, ncyc, err);
      play(limit);
   endtask

   function automatic int pick_wait();
      int r;
      r = int'($urandom_range(0, 19));
      if (r < 12)  return 0;
      if (r < 17)  return int'($urandom_range(1, 3));
      if (r == 17) return TO - 2;
      if (r == 18) return TO - 1;
      return TO;
   endfunction

   task automatic rand_tx(input bit en);
      logic [31:0] ins;
      int          n;
      bit          e;
      ins = $urandom();
      case ($urandom_range(0, 9))
         0: begin ins[6:0] = 7'h03; ins[14:12] = 3'd2; end
         1: begin ins[6:0] = 7'h23; ins[14:12] = 3'd2; end
         2: ins[6:0] = 7'h33;
         3: begin ins[6:0] = 7'h13; ins[14:12] = 3'd0; end
         4: begin ins[6:0] = 7'h13; ins[14:12] = 3'd4; end
         5: begin ins[6:0] = 7'h63; ins[14:12] = 3'd0; end
         6: ins[6:0] = 7'h6F;
         7: ins[6:0] = 7'h37;
         8: begin ins[6:0] = 7'h63; ins[14:12] = 3'd1; end
         default: begin ins[6:0] = 7'h03; ins[14:12] = 3'd0; end
      endcase
      run_tx(ins, en, pick_wait(), pick_wait(), rb(), -1, n, e);
      if (e) do_reset(sel);
   endtask

   initial begin
      int n;
      bit e;
      rst1 = 1'b1; rst0 = 1'b1; instr = '0; zero = 1'b0; mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // ---- dut1: I-type enabled ----
      sel = 1'b1;
      do_reset(1'b1);
      run_tx(32'h00500093, 1'b1, 0, 0, 1'b0, -1, n, e);   // ADDI x1,x0,5
      lit("addi_cycles", 32'(n), 32'd4);
      lit("addi_instret", cnt1, 32'd1);

      mdr_seen = 0; req_seen = 0;
      run_tx(32'h0000A103, 1'b1, 0, 3, 1'b0, -1, n, e);   // LW x2,0(x1), 3 waits
      lit("lw_cycles", 32'(n), 32'd8);
      lit("lw_mdrwrite_count", 32'(mdr_seen), 32'd1);
      lit("lw_req_cycles", 32'(req_seen), 32'd5);

      run_tx(32'h0020A223, 1'b1, 0, 0, 1'b0, -1, n, e);   // SW x2,4(x1)
      lit("sw_cycles", 32'(n), 32'd4);
      lit("sw_instret", cnt1, 32'd3);

      run_tx(32'h00000463, 1'b1, 0, 0, 1'b1, -1, n, e);   // BEQ taken
      run_tx(32'h00000463, 1'b1, 0, 0, 1'b0, -1, n, e);   // BEQ not taken
      lit("beq_cycles", 32'(n), 32'd3);
      lit("beq_instret", cnt1, 32'd5);

      run_tx(32'h00500093, 1'b1, TO, 0, 1'b0, -1, n, e);  // fetch timeout
      lit("timeout_model", 32'(e), 32'd1);
      lit("timeout_mem_err", 32'(err1), 32'd1);
      do_reset(1'b1);
      run_tx(32'h00500093, 1'b1, TO - 1, 0, 1'b0, -1, n, e); // ready on the limit cycle
      lit("limit_mem_err", 32'(err1), 32'd0);
      lit("limit_instret", cnt1, 32'd1);

      // Reset in the middle of a fetch wait drops the request immediately
      run_tx(32'h00500093, 1'b1, 5, 0, 1'b0, 3, n, e);
      chk_en = 1'b0;
      lit("req_before_rst", 32'(mem1.mem_req), 32'd1);
      #2 rst1 = 1'b1;
      #1;
      lit("rst_drops_req", 32'(mem1.mem_req), 32'd0);
      lit("rst_clears_instret", cnt1, 32'd0);
      @(posedge clk);
      #1;
      do_reset(1'b1);

      for (int i = 0; i < 200; i++) rand_tx(1'b1);

      // ---- dut0: I-type disabled, 4-bit counter ----
      rst1 = 1'b1;
      sel  = 1'b0;
      do_reset(1'b0);
      run_tx(32'h0040C093, 1'b0, 0, 0, 1'b0, -1, n, e);   // XORI -> illegal
      lit("xori_illegal_cycles", 32'(n), 32'd2);
      lit("xori_no_count", {28'd0, cnt0}, 32'd0);
      run_tx(32'h010000EF, 1'b0, 0, 0, 1'b0, -1, n, e);   // JAL x1,16
      lit("jal_cycles", 32'(n), 32'd3);
      lit("jal_instret", {28'd0, cnt0}, 32'd1);

      // Reset during JAL_EXEC clears the counter
      run_tx(32'h010000EF, 1'b0, 0, 0, 1'b0, 2, n, e);
      chk_en = 1'b0;
      #1;
      lit("jal_exec_pcwrite", 32'(pcw0), 32'd1);
      #1 rst0 = 1'b1;
      #1;
      lit("rst_mid_jal_instret", {28'd0, cnt0}, 32'd0);
      lit("rst_mid_jal_pcwrite", 32'(pcw0), 32'd0);
      @(posedge clk);
      #1;
      do_reset(1'b0);

      for (int i = 0; i < 100; i++) rand_tx(1'b0);

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule

// File: doc/rv_ctl_hs.md
Name: rv_ctl_hs

Overview:
Second-generation control plane for the multicycle RISC-V model. It drives the same datapath control signals as the current controller, with three additions:
- A req/ready handshake to variable-latency memory, with a wait-state timeout.
- A parametrised I-type ALU path (ADDI, XORI).
- A retired-instruction counter plus error/illegal status.

It sits between the datapath (instr, zero) and the unified instruction/data memory.

Parameters:
TIMEOUT, 15, max wait cycles for mem_ready before error (1..255)
EN_ITYPE, 1, 1 = ADDI/XORI executed; 0 = treated as illegal
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
instr  in  32  current IR contents
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes current request
mem_req  out  1  memory request valid
memrw  out  1  1 = write, 0 = read; valid with mem_req
pcsourse  out  1  PC_INC / PC_ALU
pcwrite  out  1  PC write enable
pccen  out  1  PC-copy register enable
irwrite  out  1  IR write enable
mdrwrite  out  1  MDR write enable
wbsel  out  2  writeback mux select
regwen  out  1  register-file write enable
immsel  out  2  immediate type
asel  out  2  ALU A mux
bsel  out  2  ALU B mux
alusel  out  4  ALU operation
instret  out  CNT_W  retired-instruction count
mem_err  out  1  sticky memory-timeout flag
illegal  out  1  one-cycle pulse on unimplemented instruction

Behaviour:
- One clock (clk); reset is asynchronous and active-high (rst).
- While rst is high: state=FETCH, instret=0, mem_err=0, wait counter=0, all strobes forced to 0, muxes to package defaults (PC_INC, WB_PC, IMM_B, ALUA_REG, ALUB_REG, ALU_ADD).
- Reset mid-operation aborts any request immediately; mem_req drops in the same cycle.
- Decode key is {instr[6:0], instr[14:12]}, with don't-care funct3 for ALU/JAL.
- States: FETCH, DECODE, ADDR, LW_MEM, LW_WB, SW_MEM, RTYPE_ALU, ITYPE_ALU, ALU_WB, BEQ_EXEC, JAL_EXEC, ERROR.
- Memory states are FETCH (read), LW_MEM (read) and SW_MEM (write):
  - mem_req=1, with memrw fixed for the whole state.
  - Request held stable until a cycle with mem_ready=1.
  - mem_ready while mem_req=0 is ignored.
- FETCH:
  - on mem_ready: pcwrite=pccen=irwrite=1, pcsourse=PC_INC, next DECODE.
  - otherwise stay in FETCH.
- LW_MEM: on mem_ready, mdrwrite=1, next LW_WB.
- SW_MEM: on mem_ready, next FETCH.
- Wait counter:
  - clears on entry to any memory state; increments each cycle mem_ready=0.
  - if it reaches TIMEOUT with mem_ready=0: next ERROR, mem_err<=1.
  - if mem_ready=1 on the same cycle the counter reaches TIMEOUT, ready wins.
- ERROR: all strobes 0, mem_req=0; terminal until rst.
- DECODE:
  - drives asel=ALUA_PCC, bsel=ALUB_IMM, immsel=IMM_B, ALU_ADD (branch-target precompute).
  - LW/SW → ADDR; R-type → RTYPE_ALU; BEQ → BEQ_EXEC; JAL → JAL_EXEC.
  - ADDI/XORI → ITYPE_ALU if EN_ITYPE.
  - else: illegal=1 for one cycle, next FETCH, not counted.
- ADDR: asel=REG, bsel=IMM, ALU_ADD; immsel=IMM_L for LW, IMM_S for SW; next LW_MEM or SW_MEM.
- RTYPE_ALU: alusel={instr[14:12], instr[30]}; next ALU_WB.
- ITYPE_ALU: immsel=IMM_L, bsel=IMM, alusel={instr[14:12], 1'b0}; next ALU_WB.
- ALU_WB: wbsel=WB_ALUOUT, regwen=1.
- LW_WB: wbsel=WB_MDR, regwen=1.
- BEQ_EXEC: ALU_SUB REG/REG, pcsourse=PC_ALU, pcwrite=zero.
- JAL_EXEC: PCC+IMM, pcsourse=PC_ALU, pcwrite=1, regwen=1, wbsel=WB_PC.
- instret increments by 1 in the final cycle of each retired instruction: LW_WB, SW_MEM accept, ALU_WB, BEQ_EXEC, JAL_EXEC. It wraps modulo 2^CNT_W.
- Latency at zero wait states:
  - LW = 5 cycles; SW = 4; R/I-type = 4; BEQ/JAL = 3.
  - Each wait cycle adds 1.

Decomposition:
- Package rv_ctl_pkg holds:
  - opcode_funct3 constants (LW, SW, ALU, BEQ, JAL, ADDI, XORI).
  - mux-select constants (PC_*, WB_*, IMM_*, ALUA_*, ALUB_*, ALU_*).
  - state enum type.
- One sub-module, rv_mem_wait: wait counter plus timeout compare, parametrised by TIMEOUT. Inputs: start, ready. Output: expired.
- Everything else stays in rv_ctl_hs.

Test Plan:
- ADDI x1,x0,5 (0x00500093), mem_ready always 1 → DECODE→ITYPE_ALU→ALU_WB, regwen in cycle 4, instret 0→1.
- LW x2,0(x1) (0x0000A103), mem_ready low 3 cycles in LW_MEM → mdrwrite exactly once on the ready cycle, mem_req held 4 cycles, total 8 cycles.
- SW x2,4(x1) (0x0020A223) → immsel=IMM_S in ADDR, memrw=1 with mem_req, regwen never asserted, instret +1.
- BEQ x0,x0,8 (0x00000463) with zero=1 → pcwrite=1, pcsourse=PC_ALU; repeat with zero=0 → pcwrite=0. Both retire.
- mem_ready stuck 0 in FETCH, TIMEOUT=15 → ERROR after 15 wait cycles, mem_err=1; ready arriving on cycle 15 instead → DECODE, mem_err=0.
- EN_ITYPE=0 with XORI (0x0040C093), then JAL x1,16 (0x010000EF) → illegal pulse, no increment; JAL retires; async rst mid-JAL clears instret to 0.
